// File: rtl/ft600_pkg.sv
// Shared widths and the beat slice helper for the FT600 transmit path.
package ft600_pkg;

  localparam int WORD_W     = 128;
  localparam int BEAT_W     = 32;
  localparam int BEATS      = WORD_W / BEAT_W;
  localparam int BEAT_IDX_W = 2;

  typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

  localparam beat_idx_t BEAT_LAST = beat_idx_t'(BEATS - 1);

  // Beat n of a word: lsw_first walks up from bit 0, otherwise down from the top.
  function automatic logic [BEAT_W-1:0] beat_slice(input logic [WORD_W-1:0] word,
                                                   input beat_idx_t        idx,
                                                   input bit               lsw_first);
    beat_idx_t sel;
    sel = lsw_first ? idx : (BEAT_LAST - idx);
    return word[sel*BEAT_W +: BEAT_W];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with explicit occupancy count; drops pushes when full.
module sync_fifo
  #(parameter int W     = 128,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1)
  (input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [W-1:0]     din,
   input  logic             pop,
   output logic [W-1:0]     dout,
   output logic [CNT_W-1:0] count,
   output logic             full);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign dout    = mem[rd_ptr];

  // Storage, pointers and count; storage is cleared so the head word is never X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ft600_tx_serializer.sv
// Buffers 128-bit words and emits them as 32-bit beats with a last-beat flag.
module ft600_tx_serializer
  import ft600_pkg::*;
  #(parameter int DEPTH     = 2,
    parameter bit LSW_FIRST = 1'b1)
  (input  logic              CLK,
   input  logic              RST,
   input  logic              in_enq__ENA,
   input  logic [WORD_W-1:0] in_enq_v,
   output logic              in_enq__RDY,
   output logic              out_enq__ENA,
   output logic [BEAT_W-1:0] out_enq_v,
   output logic              out_last,
   input  logic              out_enq__RDY);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WORD_W-1:0] head;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              has_data;
  logic              pop;
  beat_idx_t         beat;

  assign has_data     = (count != '0);
  assign in_enq__RDY  = !RST && !full;
  assign out_enq__ENA = has_data && out_enq__RDY;
  assign out_last     = has_data && (beat == BEAT_LAST);
  assign out_enq_v    = beat_slice(head, beat, LSW_FIRST);
  assign pop          = out_enq__ENA && (beat == BEAT_LAST);

  sync_fifo #(.W(WORD_W), .DEPTH(DEPTH)) u_fifo
    (.clk   (CLK),
     .rst   (RST),
     .push  (in_enq__ENA),
     .din   (in_enq_v),
     .pop   (pop),
     .dout  (head),
     .count (count),
     .full  (full));

  // Beat position within the head word; advances only on a transferred beat.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                 beat <= '0;
    else if (out_enq__ENA)   beat <= (beat == BEAT_LAST) ? '0 : beat + beat_idx_t'(1);
  end

  // A producer must never push while the buffer is not ready.
  a_no_push_when_full: assert property (@(posedge CLK) disable iff (RST)
                                        !(in_enq__ENA && !in_enq__RDY));

endmodule

// File: tb/tb_ft600_tx_serializer.sv
// Randomized and directed bench for ft600_tx_serializer, both beat orders.
module tb_ft600_tx_serializer;
  import ft600_pkg::*;

  localparam int DEPTH = 2;

  logic         CLK = 1'b0;
  logic         RST;
  logic         in_ena;
  logic [127:0] in_v;
  logic         ordy;
  logic         rdy_l, ena_l, last_l, rdy_m, ena_m, last_m;
  logic [31:0]  v_l, v_m;

  logic [32:0]  bq_l [$];
  logic [32:0]  bq_m [$];
  int           n_pass = 0;
  int           n_total = 0;

  logic [127:0] w_fix = 128'h44444444_33333333_22222222_11111111;
  logic [31:0]  c_l [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  logic [31:0]  c_m [4] = '{32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

  always #5 CLK = ~CLK;

  ft600_tx_serializer #(.DEPTH(DEPTH), .LSW_FIRST(1'b1)) dut_l
    (.CLK(CLK), .RST(RST), .in_enq__ENA(in_ena), .in_enq_v(in_v), .in_enq__RDY(rdy_l),
     .out_enq__ENA(ena_l), .out_enq_v(v_l), .out_last(last_l), .out_enq__RDY(ordy));

  ft600_tx_serializer #(.DEPTH(DEPTH), .LSW_FIRST(1'b0)) dut_m
    (.CLK(CLK), .RST(RST), .in_enq__ENA(in_ena), .in_enq_v(in_v), .in_enq__RDY(rdy_m),
     .out_enq__ENA(ena_m), .out_enq_v(v_m), .out_last(last_m), .out_enq__RDY(ordy));

  // Reference model: every pushed word becomes BEATS queued beats; a word occupies
  // storage until its last beat leaves.
  function automatic int m_words();
    return (bq_l.size() + BEATS - 1) / BEATS;
  endfunction
  function automatic logic m_rdy();
    return m_words() < DEPTH;
  endfunction
  function automatic logic m_ena();
    return (bq_l.size() != 0) && ordy;
  endfunction
  function automatic logic m_last();
    return (bq_l.size() != 0) && bq_l[0][32];
  endfunction

  task automatic drive(input logic e, input logic [127:0] v, input logic r);
    @(negedge CLK);
    in_ena = e;
    in_v   = v;
    ordy   = r;
    #1;
  endtask

  task automatic commit();
    bit pushed, popped;
    pushed = in_ena && m_rdy();
    popped = m_ena();
    if (popped) begin
      void'(bq_l.pop_front());
      void'(bq_m.pop_front());
    end
    if (pushed)
      for (int b = 0; b < BEATS; b++) begin
        bq_l.push_back({b == BEATS-1, in_v[32*b +: 32]});
        bq_m.push_back({b == BEATS-1, in_v[32*(BEATS-1-b) +: 32]});
      end
    @(posedge CLK);
  endtask

  task automatic test_reset();
    in_ena = 1'b0; in_v = '0; ordy = 1'b1;
    #2;
    n_total++; if (rdy_l !== 1'b0) $display("FAIL reset_rdy: got %b want 0", rdy_l); else n_pass++;
    n_total++; if (ena_l !== 1'b0) $display("FAIL reset_ena: got %b want 0", ena_l); else n_pass++;
    n_total++; if (last_l !== 1'b0) $display("FAIL reset_last: got %b want 0", last_l); else n_pass++;
    n_total++; if ($isunknown(v_l) || $isunknown(v_m))
      $display("FAIL reset_v_known: got %h/%h want no X", v_l, v_m); else n_pass++;
    @(negedge CLK); RST = 1'b0; #1;
    n_total++; if (rdy_l !== 1'b1 || rdy_m !== 1'b1)
      $display("FAIL reset_release_rdy: got %b/%b want 1", rdy_l, rdy_m); else n_pass++;
  endtask

  task automatic test_single();
    drive(1'b1, w_fix, 1'b1);
    n_total++; if (ena_l !== 1'b0) $display("FAIL single_ena_c0: got %b want 0", ena_l); else n_pass++;
    commit();
    for (int b = 0; b < 4; b++) begin
      drive(1'b0, '0, 1'b1);
      n_total++; if (ena_l !== 1'b1 || ena_m !== 1'b1)
        $display("FAIL single_ena b%0d: got %b/%b want 1", b, ena_l, ena_m); else n_pass++;
      n_total++; if (v_l !== c_l[b]) $display("FAIL single_lsw_v b%0d: got %h want %h", b, v_l, c_l[b]); else n_pass++;
      n_total++; if (v_m !== c_m[b]) $display("FAIL single_msw_v b%0d: got %h want %h", b, v_m, c_m[b]); else n_pass++;
      n_total++; if (last_l !== (b == 3) || last_m !== (b == 3))
        $display("FAIL single_last b%0d: got %b/%b want %b", b, last_l, last_m, b == 3); else n_pass++;
      commit();
    end
    drive(1'b0, '0, 1'b1);
    n_total++; if (ena_l !== 1'b0 || last_l !== 1'b0)
      $display("FAIL single_idle: got ena %b last %b want 0 0", ena_l, last_l); else n_pass++;
    commit();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(i < 2, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
      n_total++; if (rdy_l !== (i < 2)) $display("FAIL b2b_fill_rdy c%0d: got %b want %b", i, rdy_l, i < 2); else n_pass++;
      n_total++; if (ena_l !== 1'b0) $display("FAIL b2b_stall_ena c%0d: got %b want 0", i, ena_l); else n_pass++;
      commit();
    end
    for (int k = 0; k < 9; k++) begin
      drive(1'b0, '0, 1'b1);
      n_total++; if (ena_l !== (k < 8)) $display("FAIL b2b_ena k%0d: got %b want %b", k, ena_l, k < 8); else n_pass++;
      n_total++; if (rdy_l !== (k >= 4)) $display("FAIL b2b_rdy k%0d: got %b want %b", k, rdy_l, k >= 4); else n_pass++;
      if (k < 8) begin
        n_total++; if (v_l !== bq_l[0][31:0] || last_l !== bq_l[0][32])
          $display("FAIL b2b_beat k%0d: got %h/%b want %h/%b", k, v_l, last_l, bq_l[0][31:0], bq_l[0][32]); else n_pass++;
      end
      commit();
    end
  endtask

  task automatic test_push_on_pop();
    logic [127:0] w1, w2;
    w1 = {$urandom, $urandom, $urandom, $urandom};
    w2 = {$urandom, $urandom, $urandom, $urandom};
    drive(1'b1, w1, 1'b1); commit();
    for (int b = 0; b < 4; b++) begin
      drive(b == 3, w2, 1'b1);
      n_total++; if (rdy_l !== 1'b1) $display("FAIL pop_push_rdy b%0d: got %b want 1", b, rdy_l); else n_pass++;
      n_total++; if (v_l !== w1[32*b +: 32] || last_l !== (b == 3))
        $display("FAIL pop_push_w1 b%0d: got %h/%b want %h/%b", b, v_l, last_l, w1[32*b +: 32], b == 3); else n_pass++;
      commit();
    end
    for (int b = 0; b < 4; b++) begin
      drive(1'b0, '0, 1'b1);
      n_total++; if (ena_l !== 1'b1 || v_l !== w2[32*b +: 32] || v_m !== w2[32*(3-b) +: 32])
        $display("FAIL pop_push_w2 b%0d: got %b %h %h want 1 %h %h", b, ena_l, v_l, v_m,
                 w2[32*b +: 32], w2[32*(3-b) +: 32]); else n_pass++;
      commit();
    end
  endtask

  task automatic test_random();
    int pushed, lasts, cyc;
    logic e, r;
    logic [127:0] v;
    pushed = 0; lasts = 0; cyc = 0;
    while ((pushed < 100 || bq_l.size() != 0) && cyc < 6000) begin
      r = 1'($urandom_range(0, 1));
      e = (pushed < 100) && m_rdy() && ($urandom_range(0, 3) != 0);
      v = {$urandom, $urandom, $urandom, $urandom};
      drive(e, v, r);
      n_total++; if (rdy_l !== m_rdy() || rdy_m !== m_rdy())
        $display("FAIL rand_rdy c%0d: got %b/%b want %b", cyc, rdy_l, rdy_m, m_rdy()); else n_pass++;
      n_total++; if (ena_l !== m_ena() || ena_m !== m_ena())
        $display("FAIL rand_ena c%0d: got %b/%b want %b", cyc, ena_l, ena_m, m_ena()); else n_pass++;
      n_total++; if (last_l !== m_last() || last_m !== m_last())
        $display("FAIL rand_last c%0d: got %b/%b want %b", cyc, last_l, last_m, m_last()); else n_pass++;
      if (m_ena()) begin
        n_total++; if (v_l !== bq_l[0][31:0] || v_m !== bq_m[0][31:0])
          $display("FAIL rand_beat c%0d: got %h/%h want %h/%h", cyc, v_l, v_m, bq_l[0][31:0], bq_m[0][31:0]); else n_pass++;
      end
      if (ena_l && last_l) lasts++;
      if (e) pushed++;
      commit();
      cyc++;
    end
    n_total++; if (cyc >= 6000) $display("FAIL rand_timeout: got %0d cycles want <6000", cyc); else n_pass++;
    n_total++; if (lasts !== 100) $display("FAIL rand_last_count: got %0d want 100", lasts); else n_pass++;
  endtask

  task automatic test_mid_reset();
    drive(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1); commit();
    drive(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1); commit();
    drive(1'b0, '0, 1'b1); commit();
    @(negedge CLK); in_ena = 1'b0; RST = 1'b1; #1;
    n_total++; if (ena_l !== 1'b0 || ena_m !== 1'b0)
      $display("FAIL midrst_ena: got %b/%b want 0", ena_l, ena_m); else n_pass++;
    n_total++; if (rdy_l !== 1'b0) $display("FAIL midrst_rdy: got %b want 0", rdy_l); else n_pass++;
    @(posedge CLK);
    @(negedge CLK); RST = 1'b0;
    bq_l.delete(); bq_m.delete();
    @(posedge CLK);
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, '0, 1'b1);
      n_total++; if (rdy_l !== 1'b1) $display("FAIL midrst_release_rdy k%0d: got %b want 1", k, rdy_l); else n_pass++;
      n_total++; if (ena_l !== 1'b0 || last_l !== 1'b0)
        $display("FAIL midrst_stale k%0d: got ena %b last %b want 0 0", k, ena_l, last_l); else n_pass++;
      commit();
    end
  endtask

  initial begin
    RST = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_push_on_pop();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
